// File: rtl/pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_mem_arbiter
//
// Owner of the unified 2^AW x DW memory of the pipelined MIPS32 core. Three
// requesters share the single memory port, and at most one access is made per
// clock:
//    - d : MEM stage (load / store)
//    - f : IF stage (instruction fetch, read only)
//    - l : external loader / debug port (preload and inspection)
//
// Normal priority is d > f > l. The loader is promoted to the top (l > d > f)
// while the pipeline is halted, or once it has been denied STARVE_LIM cycles
// in a row. Read data comes back on one shared registered bus, one cycle
// after the grant, with a per-port valid strobe.
//
// Ports:
//    clk1               clock, rising edge
//    rst_n              asynchronous active-low reset
//    d_req/d_we         MEM-stage request / store enable
//    d_addr/d_wdata     MEM-stage word address / store data
//    d_gnt, d_rvalid    MEM-stage grant (combinational) / read data valid
//    f_req/f_addr       fetch request / fetch word address
//    f_gnt, f_rvalid    fetch grant / fetched instruction valid
//    l_req/l_we         loader request / write enable
//    l_addr/l_wdata     loader word address / write data
//    l_gnt, l_rvalid    loader grant / loader read data valid
//    rdata              shared registered read data
//    halted             pipeline halted; gives the loader top priority
//    if_stall           fetch requested but not granted this cycle
//    mem_stall          MEM stage requested but not granted this cycle
// -----------------------------------------------------------------------------
module pipe_mem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 8
) (
   input  logic          clk1,
   input  logic          rst_n,

   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,

   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,

   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,

   output logic [DW-1:0] rdata,

   input  logic          halted,
   output logic          if_stall,
   output logic          mem_stall
);

   localparam int NPORT = 3;
   localparam int P_D   = 0;
   localparam int P_F   = 1;
   localparam int P_L   = 2;
   localparam int DEPTH = 1 << AW;
   localparam logic [7:0] STARVE_LIM_8 = 8'(STARVE_LIM);

   // ------------------------------------------------------------------
   // Requesters gathered into port-indexed vectors so the access mux and
   // the valid strobes can be built uniformly.
   // ------------------------------------------------------------------
   logic [NPORT-1:0] req_vec;
   logic [NPORT-1:0] we_vec;
   logic [NPORT-1:0] gnt_vec;
   logic [AW-1:0]    addr_vec  [NPORT];
   logic [DW-1:0]    wdata_vec [NPORT];

   assign req_vec = {l_req, f_req, d_req};
   // The fetch port can only read.
   assign we_vec  = {l_we, 1'b0, d_we};

   assign addr_vec[P_D]  = d_addr;
   assign addr_vec[P_F]  = f_addr;
   assign addr_vec[P_L]  = l_addr;
   assign wdata_vec[P_D] = d_wdata;
   assign wdata_vec[P_F] = '0;
   assign wdata_vec[P_L] = l_wdata;

   // ------------------------------------------------------------------
   // Loader starvation counter and promotion
   // ------------------------------------------------------------------
   logic [7:0] starve_cnt_reg;
   logic [7:0] starve_cnt_next;
   logic       promote;

   assign promote = halted | (starve_cnt_reg == STARVE_LIM_8);

   always_comb begin
      starve_cnt_next = 8'd0;
      if (l_req && !gnt_vec[P_L]) begin
         if (starve_cnt_reg >= STARVE_LIM_8)
            starve_cnt_next = STARVE_LIM_8;
         else
            starve_cnt_next = starve_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)
         starve_cnt_reg <= 8'd0;
      else
         starve_cnt_reg <= starve_cnt_next;
   end

   // ------------------------------------------------------------------
   // Grant selection: purely combinational from the current requests,
   // so a rising halted or a counter reaching its limit takes effect in
   // the same cycle. The if/else chain guarantees a one-hot (or empty)
   // grant vector.
   // ------------------------------------------------------------------
   always_comb begin
      gnt_vec = '0;
      if (promote && req_vec[P_L])
         gnt_vec[P_L] = 1'b1;
      else if (req_vec[P_D])
         gnt_vec[P_D] = 1'b1;
      else if (req_vec[P_F])
         gnt_vec[P_F] = 1'b1;
      else if (req_vec[P_L])
         gnt_vec[P_L] = 1'b1;
   end

   assign d_gnt     = gnt_vec[P_D];
   assign f_gnt     = gnt_vec[P_F];
   assign l_gnt     = gnt_vec[P_L];
   assign if_stall  = f_req & ~gnt_vec[P_F];
   assign mem_stall = d_req & ~gnt_vec[P_D];

   // ------------------------------------------------------------------
   // Access mux: AND-OR select of the granted port's fields. Since the
   // grant is one-hot this is equivalent to a priority mux but shallower.
   // ------------------------------------------------------------------
   logic [AW-1:0] addr_masked  [NPORT];
   logic [DW-1:0] wdata_masked [NPORT];
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;
   logic          acc_wr;
   logic          acc_rd;

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_acc_mask
      assign addr_masked[gi]  = gnt_vec[gi] ? addr_vec[gi]  : '0;
      assign wdata_masked[gi] = gnt_vec[gi] ? wdata_vec[gi] : '0;
   end

   always_comb begin
      acc_addr  = '0;
      acc_wdata = '0;
      for (int i = 0; i < NPORT; i++) begin
         acc_addr  = acc_addr  | addr_masked[i];
         acc_wdata = acc_wdata | wdata_masked[i];
      end
   end

   assign acc_wr = |(gnt_vec & we_vec);
   assign acc_rd = (|gnt_vec) & ~acc_wr;

   // ------------------------------------------------------------------
   // Memory array. Contents are never cleared; the reset branch is left
   // empty on purpose so that a grant that happens while rst_n is low
   // cannot write the array.
   // ------------------------------------------------------------------
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
      end else if (acc_wr) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   // Registered read port; holds its value when no read is granted.
   logic [DW-1:0] rdata_reg;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)
         rdata_reg <= '0;
      else if (acc_rd)
         rdata_reg <= mem[acc_addr];
   end

   assign rdata = rdata_reg;

   // ------------------------------------------------------------------
   // Per-port read-valid strobes: high for exactly one cycle after a
   // granted read on that port, never after a write.
   // ------------------------------------------------------------------
   logic rvalid_reg [NPORT];

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_rvalid
      always_ff @(posedge clk1 or negedge rst_n) begin
         if (!rst_n)
            rvalid_reg[gi] <= 1'b0;
         else
            rvalid_reg[gi] <= gnt_vec[gi] & ~we_vec[gi];
      end
   end

   assign d_rvalid = rvalid_reg[P_D];
   assign f_rvalid = rvalid_reg[P_F];
   assign l_rvalid = rvalid_reg[P_L];

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipe_mem_arbiter
//
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model: a word array with "written" flags, a count of
// consecutive denied loader cycles, and the priority rules.
// -----------------------------------------------------------------------------
module tb_pipe_mem_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int LIM = 8;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          d_req, d_we, f_req, l_req, l_we, halted;
   logic [AW-1:0] d_addr, f_addr, l_addr;
   logic [DW-1:0] d_wdata, l_wdata;
   logic          d_gnt, d_rvalid, f_gnt, f_rvalid, l_gnt, l_rvalid;
   logic          if_stall, mem_stall;
   logic [DW-1:0] rdata;

   pipe_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid),
      .rdata(rdata), .halted(halted),
      .if_stall(if_stall), .mem_stall(mem_stall)
   );

   always #5 clk1 = ~clk1;

   // ---------------- reference model state ----------------
   logic [DW-1:0] mem_m   [1 << AW];
   bit            known_m [1 << AW];
   int            starve_m;
   logic [2:0]    exp_rv;
   logic [DW-1:0] exp_rdata;
   bit            exp_rdata_known;
   logic [2:0]    last_gnt;
   int            cyc_n;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   // Grant by the priority rules: promoted loader first, else d > f > l.
   function automatic logic [2:0] model_gnt(input logic dr, fr, lr, hl, input int sc);
      bit promo;
      promo = hl || (sc == LIM);
      if (promo && lr) return 3'b100;
      if (dr)          return 3'b001;
      if (fr)          return 3'b010;
      if (lr)          return 3'b100;
      return 3'b000;
   endfunction

   // One clock of traffic with the currently driven inputs.
   task automatic cycle();
      logic [2:0]    eg;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      string         who;
      #2;
      eg = model_gnt(d_req, f_req, l_req, halted, starve_m);
      check_eq("d_gnt", d_gnt, eg[0]);
      check_eq("f_gnt", f_gnt, eg[1]);
      check_eq("l_gnt", l_gnt, eg[2]);
      check_eq("if_stall", if_stall, f_req & ~eg[1]);
      check_eq("mem_stall", mem_stall, d_req & ~eg[0]);
      last_gnt = eg;
      we = 1'b0; a = '0; wd = '0; who = "--";
      if (eg[0]) begin who = "d"; we = d_we; a = d_addr; wd = d_wdata; end
      if (eg[1]) begin who = "f"; we = 1'b0; a = f_addr; end
      if (eg[2]) begin who = "l"; we = l_we; a = l_addr; wd = l_wdata; end
      if (eg != 3'b000)
         $display("cyc %0d: port %s %s addr=%h wdata=%h halted=%0d", cyc_n, who,
                  we ? "WR" : "RD", a, wd, halted);
      if (l_req && !eg[2]) starve_m = (starve_m >= LIM) ? LIM : starve_m + 1;
      else                 starve_m = 0;
      @(posedge clk1);
      cyc_n++;
      exp_rv = 3'b000;
      if (eg != 3'b000) begin
         if (we) begin
            mem_m[a] = wd;
            known_m[a] = 1'b1;
         end else begin
            exp_rv = eg;
            exp_rdata = mem_m[a];
            exp_rdata_known = known_m[a];
         end
      end
      #1;
      check_eq("rvalid", {l_rvalid, f_rvalid, d_rvalid}, exp_rv);
      if (exp_rdata_known) check_eq("rdata", rdata, exp_rdata);
   endtask

   // Assert reset mid-cycle with the current inputs held, then release.
   task automatic do_reset();
      logic [2:0] eg;
      rst_n = 1'b0;
      starve_m = 0;
      #1;
      check_eq("rst_rvalid_async", {l_rvalid, f_rvalid, d_rvalid}, 3'b000);
      check_eq("rst_rdata_async", rdata, 32'h0);
      repeat (2) begin
         eg = model_gnt(d_req, f_req, l_req, halted, 0);
         check_eq("rst_gnt", {l_gnt, f_gnt, d_gnt}, eg);
         @(posedge clk1);
         cyc_n++;
         #1;
         check_eq("rst_rvalid", {l_rvalid, f_rvalid, d_rvalid}, 3'b000);
         check_eq("rst_rdata", rdata, 32'h0);
      end
      exp_rv = 3'b000;
      exp_rdata = '0;
      exp_rdata_known = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic idle_inputs();
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      f_req = 0; f_addr = '0;
      l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
      halted = 0;
   endtask

   task automatic loader_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
      l_req = 1; l_we = 1; l_addr = a; l_wdata = v;
      cycle();
      l_req = 0; l_we = 0;
   endtask

   initial begin
      int gnt_at;
      bit pend_d, pend_f, pend_l;
      cyc_n = 0;
      starve_m = 0;
      exp_rv = 0;
      exp_rdata = 0;
      exp_rdata_known = 1;
      last_gnt = 0;
      for (int i = 0; i < (1 << AW); i++) known_m[i] = 1'b0;

      // Reset with every requester active; d must win on release.
      idle_inputs();
      d_req = 1; d_we = 1; d_addr = 10'd7; d_wdata = 32'h0000_0BAD;
      f_req = 1; f_addr = 10'd1;
      l_req = 1; l_we = 1; l_addr = 10'd2; l_wdata = 32'h1111_2222;
      do_reset();
      cycle();
      check_eq("release_d_first", d_gnt, 1'b1);
      idle_inputs();
      cycle();

      // Loader preload then fetch.
      loader_write(10'd0, 32'h2801_000A);
      f_req = 1; f_addr = 10'd0;
      cycle();
      f_req = 0;
      check_eq("fetch_rvalid", f_rvalid, 1'b1);
      check_eq("fetch_rdata", rdata, 32'h2801_000A);
      cycle();

      // Priority collision: d load of 5 beats fetch of 6.
      loader_write(10'd5, 32'h0000_0055);
      loader_write(10'd6, 32'h0000_0066);
      d_req = 1; d_we = 0; d_addr = 10'd5;
      f_req = 1; f_addr = 10'd6;
      cycle();
      d_req = 0;
      cycle();
      check_eq("collision_f_gnt", last_gnt, 3'b010);
      f_req = 0;
      cycle();

      // A store granted while rst_n is low must not reach the array.
      loader_write(10'd7, 32'h7777_7777);
      d_req = 1; d_we = 1; d_addr = 10'd7; d_wdata = 32'hBADB_AD00;
      do_reset();
      d_we = 0;
      cycle();
      d_req = 0;
      check_eq("reset_no_write", rdata, 32'h7777_7777);
      cycle();

      // Starvation: continuous d and f, loader read of 3.
      loader_write(10'd3, 32'h0333_3333);
      d_req = 1; d_we = 0; d_addr = 10'd1;
      f_req = 1; f_addr = 10'd0;
      l_req = 1; l_we = 0; l_addr = 10'd3;
      gnt_at = -1;
      for (int i = 0; i < 20 && gnt_at < 0; i++) begin
         cycle();
         if (last_gnt[2]) gnt_at = i;
      end
      l_req = 0;
      check_eq("starve_gnt_cycle", gnt_at, 8);
      check_eq("starve_cnt_clear", dut.starve_cnt_reg, 8'd0);
      check_eq("starve_l_rvalid", l_rvalid, 1'b1);
      check_eq("starve_rdata", rdata, 32'h0333_3333);

      // Halted: loader wins every cycle.
      halted = 1;
      l_req = 1; l_addr = 10'd0;
      repeat (4) begin
         cycle();
         check_eq("halted_l_gnt", last_gnt, 3'b100);
      end
      idle_inputs();
      cycle();

      // Store then load at the top address.
      d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
      cycle();
      d_we = 0;
      cycle();
      d_req = 0;
      check_eq("wr_rd_rvalid", d_rvalid, 1'b1);
      check_eq("wr_rd_rdata", rdata, 32'hDEAD_BEEF);
      cycle();

      // Randomized traffic with requests held until granted.
      pend_d = 0; pend_f = 0; pend_l = 0;
      for (int n = 0; n < 400; n++) begin
         if (last_gnt[0] || !pend_d) begin
            pend_d = ($urandom_range(0, 1) == 1);
            d_we = 1'($urandom_range(0, 1));
            d_addr = AW'($urandom_range(0, 15));
            d_wdata = $urandom;
         end
         if (last_gnt[1] || !pend_f) begin
            pend_f = ($urandom_range(0, 2) != 0);
            f_addr = AW'($urandom_range(0, 15));
         end
         if (last_gnt[2] || !pend_l) begin
            pend_l = ($urandom_range(0, 2) == 0);
            l_we = 1'($urandom_range(0, 1));
            l_addr = AW'($urandom_range(0, 15));
            l_wdata = $urandom;
         end
         d_req = pend_d; f_req = pend_f; l_req = pend_l;
         if ($urandom_range(0, 19) == 0) halted = ~halted;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Hard bound on simulation time.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
